adc_lane_align_fsm: RTL and testbench
=====================================

// Module: adc_lane_align_fsm
// PURPOSE
// Automatic deserializer training for the ADC receiver. For each lane, and for I then Q, it:
// - selects the lane through the IDELAY/bitslip line mux;
// - sweeps the IDELAY taps 0..31 and loads the centre of the widest stable window;
// - bitslips until the word equals PATTERN.
// Sits directly upstream of the line mux and drives its select, IDELAY and bitslip inputs.
// PARAMETERS
// PORTS          8       number of ADC lanes; mux select width
// DATA_WIDTH_ADC 12      deserialized word width
// PATTERN        12'hA36 expected ADC training word
// SETTLE_CYCLES  16      wait after any tap change/load before sampling
// CHECK_SAMPLES  64      consecutive identical words required for a tap to pass
// SLIP_WAIT      8       wait after a bitslip pulse before re-compare
// PORTS
// clk_i          in  1                     system clock
// rstn_i         in  1                     asynchronous active-low reset
// start_i        in  1                     start training pulse; ignored while busy_o=1
// i_data_i       in  PORTS*DATA_WIDTH_ADC  deserialized I words per lane
// q_data_i       in  PORTS*DATA_WIDTH_ADC  deserialized Q words per lane
// mux_cntrl_o    out PORTS                 lane index to mux; PORTS = idle (no lane)
// i_dl_ce_o / q_dl_ce_o         out 1      IDELAY CE pulse (increment, inc=1)
// i_dl_in_o / q_dl_in_o         out 1      IDELAY INC direction, always 1 when CE=1
// i_dl_load_val_o / q_dl_load_val_o out 1  IDELAY load pulse
// i_dl_cnt_in_o / q_dl_cnt_in_o out 5      tap value for load
// bitslip_i_o / bitslip_q_o     out 1      ISERDES bitslip pulse
// busy_o         out 1                     training in progress
// done_o         out 1                     one-cycle pulse at end of full run
// ok_i_o, ok_q_o out PORTS                 per-lane channel trained successfully
// tap_i_o, tap_q_o out PORTS*5             per-lane final tap loaded
// BEHAVIOUR
// Reset values: mux_cntrl_o=PORTS, all pulses/cnt_in=0, busy_o=0, done_o=0, ok_*=0, tap_*=0. Reset mid-run aborts to IDLE.
// - start_i in IDLE: clear ok_*/tap_*, lane=0, chan=I, busy_o=1, go to SEL.
// - All pulse outputs are one cycle wide. Only the active channel's set ever toggles.
// FSM states:
// - IDLE.
// - SEL: mux_cntrl_o=lane; hold 2 cycles, all pulses low. The mux registers per-lane, so every lane change and
//   leaving to IDLE is preceded by >=2 cycles of all-low pulses at the current select.
// - LOAD0: cnt_in=0, load pulse; tap=0; clear run trackers.
// - SETTLE: count SETTLE_CYCLES.
// - SAMPLE: capture first word of selected lane/chan; pass if next CHECK_SAMPLES-1 words equal it.
//   Any mismatch ends the tap as fail immediately.
// - STEP: update trackers. If tap=31 go CENTER, else CE pulse, tap++, go SETTLE.
// - CENTER: if best_len=0, set ok=0, tap=0, go NEXT. Otherwise:
//   - centre = best_start + ((best_len-1)>>1), 5-bit result;
//   - load pulse with cnt_in=centre, record tap_*_o; SETTLE, then SLIP_CHECK.
// - SLIP_CHECK: word==PATTERN -> ok=1, NEXT. Else if slips==DATA_WIDTH_ADC -> ok=0, NEXT.
//   Else SLIP_PULSE (1 cycle), SLIP_WAIT cycles, slips++, re-check.
// - NEXT: chan I->Q (same lane, skip SEL), Q->I with lane++. After lane PORTS-1 Q: mux_cntrl_o=PORTS after 2 quiet cycles,
//   done_o pulse, busy_o=0, IDLE.
// Window tracking:
// - cur_start/cur_len (6-bit) extend on pass, close on fail.
// - Closed run replaces best only if strictly longer (earliest window wins ties).
// - Run still open at tap 31 is closed at end of sweep.
// TESTING
// 1 lane0 I eye taps 10..19, pattern after 3 slips -> tap_i_o[0]=14, 3 bitslip_i pulses, ok_i_o[0]=1.
// 2 lane3 Q never stable -> ok_q_o[3]=0, tap_q_o[3]=0, no bitslip_q pulses on lane3; all others ok.
// 3 eyes 2..5 and 20..27 -> 23; equal eyes 2..5 and 20..23 -> 3; eye 24..31 (open at end) -> 27.
// 4 stable but pattern never matches -> exactly DATA_WIDTH_ADC slips, ok=0, run continues to next channel.
// 5 assert rstn_i mid-sweep lane5 -> outputs at reset values immediately; start_i while busy ignored; done_o single pulse.
// 6 checker: mux_cntrl_o changes only after >=2 cycles of all pulses low; CE count per sweep =31.

Source files
------------

// File: rtl/adc_lane_align_fsm.sv
// Deserializer training sequencer: per lane and channel, sweeps IDELAY taps, loads the centre
// of the widest stable window, then bitslips until the training word is seen.
module adc_lane_align_fsm #(
    parameter int                        PORTS          = 8,
    parameter int                        DATA_WIDTH_ADC = 12,
    parameter logic [DATA_WIDTH_ADC-1:0] PATTERN        = 12'hA36,
    parameter int                        SETTLE_CYCLES  = 16,
    parameter int                        CHECK_SAMPLES  = 64,
    parameter int                        SLIP_WAIT      = 8
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              start_i,
    input  logic [PORTS*DATA_WIDTH_ADC-1:0]   i_data_i,
    input  logic [PORTS*DATA_WIDTH_ADC-1:0]   q_data_i,
    output logic [PORTS-1:0]                  mux_cntrl_o,
    output logic                              i_dl_ce_o,
    output logic                              q_dl_ce_o,
    output logic                              i_dl_in_o,
    output logic                              q_dl_in_o,
    output logic                              i_dl_load_val_o,
    output logic                              q_dl_load_val_o,
    output logic [4:0]                        i_dl_cnt_in_o,
    output logic [4:0]                        q_dl_cnt_in_o,
    output logic                              bitslip_i_o,
    output logic                              bitslip_q_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [PORTS-1:0]                  ok_i_o,
    output logic [PORTS-1:0]                  ok_q_o,
    output logic [PORTS*5-1:0]                tap_i_o,
    output logic [PORTS*5-1:0]                tap_q_o
);

    localparam int LANE_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CNT_W  = 16;
    localparam int SLIP_W = $clog2(DATA_WIDTH_ADC + 1);

    typedef enum logic [3:0] {
        IDLE, SEL, LOAD0, SETTLE, SAMPLE, STEP, CENTER,
        SLIP_CHECK, SLIP_PULSE, SLIP_HOLD, NEXT, QUIET
    } state_t;

    state_t                    state;
    logic [LANE_W-1:0]         lane;
    logic                      chan;
    logic [4:0]                tap;
    logic [CNT_W-1:0]          cnt;
    logic [SLIP_W-1:0]         slips;
    logic                      pass;
    logic                      aligning;
    logic                      last;
    logic [5:0]                cur_start;
    logic [5:0]                cur_len;
    logic [5:0]                best_start;
    logic [5:0]                best_len;
    logic [DATA_WIDTH_ADC-1:0] ref_word;
    logic [DATA_WIDTH_ADC-1:0] word;
    logic [5:0]                ext_start;
    logic [5:0]                ext_len;
    logic [4:0]                centre;
    logic [4:0]                tap_i_r [PORTS];
    logic [4:0]                tap_q_r [PORTS];
    logic [DATA_WIDTH_ADC-1:0] i_words [PORTS];
    logic [DATA_WIDTH_ADC-1:0] q_words [PORTS];

    for (genvar g = 0; g < PORTS; g++) begin : g_lane
        assign i_words[g]         = i_data_i[g*DATA_WIDTH_ADC +: DATA_WIDTH_ADC];
        assign q_words[g]         = q_data_i[g*DATA_WIDTH_ADC +: DATA_WIDTH_ADC];
        assign tap_i_o[g*5 +: 5]  = tap_i_r[g];
        assign tap_q_o[g*5 +: 5]  = tap_q_r[g];
    end

    assign word      = chan ? q_words[lane] : i_words[lane];
    // A passing tap either opens a new run at this tap or extends the current one.
    assign ext_start = (cur_len == 6'd0) ? {1'b0, tap} : cur_start;
    assign ext_len   = cur_len + 6'd1;
    assign centre    = 5'(best_start + ((best_len - 6'd1) >> 1));

    always_ff @(posedge clk_i) begin
        if (state == SAMPLE && cnt == '0) ref_word <= word;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state           <= IDLE;
            lane            <= '0;
            chan            <= 1'b0;
            tap             <= '0;
            cnt             <= '0;
            slips           <= '0;
            pass            <= 1'b0;
            aligning        <= 1'b0;
            last            <= 1'b0;
            cur_start       <= '0;
            cur_len         <= '0;
            best_start      <= '0;
            best_len        <= '0;
            mux_cntrl_o     <= PORTS'(PORTS);
            i_dl_ce_o       <= 1'b0;
            q_dl_ce_o       <= 1'b0;
            i_dl_in_o       <= 1'b0;
            q_dl_in_o       <= 1'b0;
            i_dl_load_val_o <= 1'b0;
            q_dl_load_val_o <= 1'b0;
            i_dl_cnt_in_o   <= '0;
            q_dl_cnt_in_o   <= '0;
            bitslip_i_o     <= 1'b0;
            bitslip_q_o     <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            ok_i_o          <= '0;
            ok_q_o          <= '0;
            for (int k = 0; k < PORTS; k++) begin
                tap_i_r[k] <= '0;
                tap_q_r[k] <= '0;
            end
        end else begin
            i_dl_ce_o       <= 1'b0;
            q_dl_ce_o       <= 1'b0;
            i_dl_in_o       <= 1'b0;
            q_dl_in_o       <= 1'b0;
            i_dl_load_val_o <= 1'b0;
            q_dl_load_val_o <= 1'b0;
            bitslip_i_o     <= 1'b0;
            bitslip_q_o     <= 1'b0;
            done_o          <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        ok_i_o <= '0;
                        ok_q_o <= '0;
                        for (int k = 0; k < PORTS; k++) begin
                            tap_i_r[k] <= '0;
                            tap_q_r[k] <= '0;
                        end
                        lane        <= '0;
                        chan        <= 1'b0;
                        last        <= 1'b0;
                        busy_o      <= 1'b1;
                        mux_cntrl_o <= '0;
                        cnt         <= '0;
                        state       <= SEL;
                    end
                end
                SEL: begin
                    if (cnt == CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= LOAD0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOAD0: begin
                    if (chan) begin
                        q_dl_load_val_o <= 1'b1;
                        q_dl_cnt_in_o   <= '0;
                    end else begin
                        i_dl_load_val_o <= 1'b1;
                        i_dl_cnt_in_o   <= '0;
                    end
                    tap        <= '0;
                    cur_start  <= '0;
                    cur_len    <= '0;
                    best_start <= '0;
                    best_len   <= '0;
                    aligning   <= 1'b0;
                    cnt        <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= aligning ? SLIP_CHECK : SAMPLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (cnt == '0) begin
                        cnt <= CNT_W'(1);
                        if (CHECK_SAMPLES <= 1) begin
                            pass  <= 1'b1;
                            state <= STEP;
                        end
                    end else if (word != ref_word) begin
                        pass  <= 1'b0;
                        state <= STEP;
                    end else if (cnt == CNT_W'(CHECK_SAMPLES - 1)) begin
                        pass  <= 1'b1;
                        state <= STEP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STEP: begin
                    cnt <= '0;
                    // Strictly-longer replacement keeps the earliest window on ties.
                    if (pass) begin
                        if (tap == 5'd31) begin
                            if (ext_len > best_len) begin
                                best_start <= ext_start;
                                best_len   <= ext_len;
                            end
                        end else begin
                            cur_start <= ext_start;
                            cur_len   <= ext_len;
                        end
                    end else begin
                        if (cur_len > best_len) begin
                            best_start <= cur_start;
                            best_len   <= cur_len;
                        end
                        cur_len <= '0;
                    end
                    if (tap == 5'd31) begin
                        state <= CENTER;
                    end else begin
                        if (chan) begin
                            q_dl_ce_o <= 1'b1;
                            q_dl_in_o <= 1'b1;
                        end else begin
                            i_dl_ce_o <= 1'b1;
                            i_dl_in_o <= 1'b1;
                        end
                        tap   <= tap + 5'd1;
                        state <= SETTLE;
                    end
                end
                CENTER: begin
                    if (best_len == 6'd0) begin
                        if (chan) begin
                            ok_q_o[lane]  <= 1'b0;
                            tap_q_r[lane] <= '0;
                        end else begin
                            ok_i_o[lane]  <= 1'b0;
                            tap_i_r[lane] <= '0;
                        end
                        state <= NEXT;
                    end else begin
                        if (chan) begin
                            q_dl_load_val_o <= 1'b1;
                            q_dl_cnt_in_o   <= centre;
                            tap_q_r[lane]   <= centre;
                        end else begin
                            i_dl_load_val_o <= 1'b1;
                            i_dl_cnt_in_o   <= centre;
                            tap_i_r[lane]   <= centre;
                        end
                        slips    <= '0;
                        aligning <= 1'b1;
                        cnt      <= '0;
                        state    <= SETTLE;
                    end
                end
                SLIP_CHECK: begin
                    if (word == PATTERN) begin
                        if (chan) ok_q_o[lane] <= 1'b1;
                        else      ok_i_o[lane] <= 1'b1;
                        state <= NEXT;
                    end else if (slips == SLIP_W'(DATA_WIDTH_ADC)) begin
                        state <= NEXT;
                    end else begin
                        if (chan) bitslip_q_o <= 1'b1;
                        else      bitslip_i_o <= 1'b1;
                        state <= SLIP_PULSE;
                    end
                end
                SLIP_PULSE: begin
                    slips <= slips + SLIP_W'(1);
                    cnt   <= '0;
                    state <= SLIP_HOLD;
                end
                SLIP_HOLD: begin
                    if (cnt == CNT_W'(SLIP_WAIT - 1)) begin
                        cnt   <= '0;
                        state <= SLIP_CHECK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                NEXT: begin
                    aligning <= 1'b0;
                    cnt      <= '0;
                    if (!chan) begin
                        chan  <= 1'b1;
                        state <= LOAD0;
                    end else begin
                        chan  <= 1'b0;
                        state <= QUIET;
                        if (lane == LANE_W'(PORTS - 1)) last <= 1'b1;
                        else                            lane <= lane + LANE_W'(1);
                    end
                end
                QUIET: begin
                    // The line mux latches per lane, so the select only moves after two idle cycles.
                    if (cnt == CNT_W'(1)) begin
                        cnt <= '0;
                        if (last) begin
                            last        <= 1'b0;
                            mux_cntrl_o <= PORTS'(PORTS);
                            done_o      <= 1'b1;
                            busy_o      <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            mux_cntrl_o <= PORTS'(lane);
                            state       <= SEL;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_lane_align_fsm.sv
// Directed bench for adc_lane_align_fsm: a per-lane IDELAY/bitslip model produces stable or
// noisy words depending on the loaded tap, and each task checks one training scenario.
module tb_adc_lane_align_fsm;

    localparam int          P     = 8;
    localparam int          W     = 12;
    localparam logic [11:0] PAT   = 12'hA36;
    localparam int          SETTLE = 3;
    localparam int          CHECK  = 4;
    localparam int          SWAIT  = 2;

    logic              clk_i = 1'b0;
    logic              rstn_i = 1'b0;
    logic              start_i = 1'b0;
    logic [P*W-1:0]    i_data_i;
    logic [P*W-1:0]    q_data_i;
    logic [P-1:0]      mux_cntrl_o;
    logic              i_dl_ce_o, q_dl_ce_o, i_dl_in_o, q_dl_in_o;
    logic              i_dl_load_val_o, q_dl_load_val_o;
    logic [4:0]        i_dl_cnt_in_o, q_dl_cnt_in_o;
    logic              bitslip_i_o, bitslip_q_o;
    logic              busy_o, done_o;
    logic [P-1:0]      ok_i_o, ok_q_o;
    logic [P*5-1:0]    tap_i_o, tap_q_o;

    adc_lane_align_fsm #(
        .PORTS(P), .DATA_WIDTH_ADC(W), .PATTERN(PAT),
        .SETTLE_CYCLES(SETTLE), .CHECK_SAMPLES(CHECK), .SLIP_WAIT(SWAIT)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
        .i_data_i(i_data_i), .q_data_i(q_data_i), .mux_cntrl_o(mux_cntrl_o),
        .i_dl_ce_o(i_dl_ce_o), .q_dl_ce_o(q_dl_ce_o),
        .i_dl_in_o(i_dl_in_o), .q_dl_in_o(q_dl_in_o),
        .i_dl_load_val_o(i_dl_load_val_o), .q_dl_load_val_o(q_dl_load_val_o),
        .i_dl_cnt_in_o(i_dl_cnt_in_o), .q_dl_cnt_in_o(q_dl_cnt_in_o),
        .bitslip_i_o(bitslip_i_o), .bitslip_q_o(bitslip_q_o),
        .busy_o(busy_o), .done_o(done_o),
        .ok_i_o(ok_i_o), .ok_q_o(ok_q_o), .tap_i_o(tap_i_o), .tap_q_o(tap_q_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Channel model configuration: up to two stable windows and the slips needed (>=12: never).
    int eye_lo [P][2];
    int eye_hi [P][2];
    int eye2_lo[P][2];
    int eye2_hi[P][2];
    int need   [P][2];

    logic [4:0]  mtap [P][2] = '{default: '0};
    int          mslip[P][2] = '{default: 0};
    logic [11:0] cyc = '0;

    function automatic logic [11:0] stable_word(input int n, input int s);
        logic [23:0] d;
        int r;
        if (n >= 12) return 12'h555;
        r = (n - s) % 12;
        if (r < 0) r += 12;
        d = {PAT, PAT};
        d = d << r;
        return d[23:12];
    endfunction

    always_comb begin
        int          t;
        bit          in_eye;
        logic [11:0] w;
        i_data_i = '0;
        q_data_i = '0;
        for (int l = 0; l < P; l++) begin
            for (int c = 0; c < 2; c++) begin
                t = int'(mtap[l][c]);
                in_eye = (t >= eye_lo[l][c] && t <= eye_hi[l][c]) ||
                         (t >= eye2_lo[l][c] && t <= eye2_hi[l][c]);
                w = in_eye ? stable_word(need[l][c], mslip[l][c]) : (cyc ^ 12'(l * 37 + c * 11));
                if (c == 0) i_data_i[l*W +: W] = w;
                else        q_data_i[l*W +: W] = w;
            end
        end
    end

    always @(posedge clk_i) begin
        int ml;
        cyc <= cyc + 12'd1;
        ml = int'(mux_cntrl_o);
        if (rstn_i && ml < P) begin
            if (i_dl_load_val_o) begin mtap[ml][0] <= i_dl_cnt_in_o; mslip[ml][0] <= 0; end
            if (i_dl_ce_o)       mtap[ml][0] <= mtap[ml][0] + 5'd1;
            if (bitslip_i_o)     mslip[ml][0] <= mslip[ml][0] + 1;
            if (q_dl_load_val_o) begin mtap[ml][1] <= q_dl_cnt_in_o; mslip[ml][1] <= 0; end
            if (q_dl_ce_o)       mtap[ml][1] <= mtap[ml][1] + 5'd1;
            if (bitslip_q_o)     mslip[ml][1] <= mslip[ml][1] + 1;
        end
    end

    // Protocol monitor, sampled on the falling edge.
    logic [5:0]   pulse_vec;
    assign pulse_vec = {i_dl_ce_o, i_dl_load_val_o, bitslip_i_o, q_dl_ce_o, q_dl_load_val_o, bitslip_q_o};

    int           ce_total = 0, done_total = 0, mux_err = 0, wide_err = 0, dir_err = 0;
    int           slip_i_cnt[P] = '{default: 0};
    int           slip_q_cnt[P] = '{default: 0};
    int           quiet = 0;
    logic [5:0]   prev_pulses = '0;
    logic [P-1:0] prev_mux = P'(P);

    always @(negedge clk_i) begin
        if (!rstn_i) begin
            quiet       = 0;
            prev_pulses = '0;
            prev_mux    = mux_cntrl_o;
        end else begin
            if ((pulse_vec & prev_pulses) != '0) wide_err++;
            if (mux_cntrl_o != prev_mux && quiet < 2) mux_err++;
            if ((i_dl_ce_o && !i_dl_in_o) || (q_dl_ce_o && !q_dl_in_o)) dir_err++;
            quiet = (pulse_vec != '0) ? 0 : ((quiet < 100) ? quiet + 1 : quiet);
            ce_total += int'(i_dl_ce_o) + int'(q_dl_ce_o);
            done_total += int'(done_o);
            if (int'(mux_cntrl_o) < P) begin
                if (bitslip_i_o) slip_i_cnt[int'(mux_cntrl_o)]++;
                if (bitslip_q_o) slip_q_cnt[int'(mux_cntrl_o)]++;
            end
            prev_pulses = pulse_vec;
            prev_mux    = mux_cntrl_o;
        end
    end

    task automatic set_default_cfg();
        for (int l = 0; l < P; l++) begin
            for (int c = 0; c < 2; c++) begin
                eye_lo[l][c] = 8;  eye_hi[l][c] = 15;
                eye2_lo[l][c] = 1; eye2_hi[l][c] = 0;
                need[l][c] = 0;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk_i);
            if (done_o) begin seen = 1; break; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL %s_done: got timeout, required done_o pulse", tag); end
    endtask

    task automatic wait_mux(input int lane, input string tag);
        bit seen = 0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk_i);
            if (int'(mux_cntrl_o) == lane) begin seen = 1; break; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL %s_mux: got timeout, required mux_cntrl_o=%0d", tag, lane); end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        total += 7;
        if (mux_cntrl_o !== 8'd8) begin bad++; $display("FAIL reset_mux: got %0d required 8", mux_cntrl_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy_o); end
        if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", done_o); end
        if ({ok_i_o, ok_q_o} !== '0) begin bad++; $display("FAIL reset_ok: got %h required 0", {ok_i_o, ok_q_o}); end
        if ({tap_i_o, tap_q_o} !== '0) begin bad++; $display("FAIL reset_tap: got %h required 0", {tap_i_o, tap_q_o}); end
        if ({pulse_vec, i_dl_in_o, q_dl_in_o} !== '0) begin bad++; $display("FAIL reset_pulses: got %b required 0", pulse_vec); end
        if ({i_dl_cnt_in_o, q_dl_cnt_in_o} !== '0) begin bad++; $display("FAIL reset_cnt_in: got %h required 0", {i_dl_cnt_in_o, q_dl_cnt_in_o}); end
        #2 rstn_i = 1'b1;
        repeat (4) @(posedge clk_i);
    endtask

    task automatic test_main_run();
        int exp_ti[P] = '{14, 23, 27, 11, 0, 11, 11, 11};
        int exp_tq[P] = '{11, 3, 15, 0, 11, 11, 11, 11};
        int exp_si[P] = '{3, 0, 11, 0, 1, 0, 0, 0};
        int exp_sq[P] = '{0, 5, 0, 0, 0, 0, 0, 0};
        int si0[P], sq0[P];
        int ce0, dn0, got;
        set_default_cfg();
        eye_lo[0][0] = 10; eye_hi[0][0] = 19; need[0][0] = 3;
        eye_lo[1][0] = 2;  eye_hi[1][0] = 5;  eye2_lo[1][0] = 20; eye2_hi[1][0] = 27;
        eye_lo[1][1] = 2;  eye_hi[1][1] = 5;  eye2_lo[1][1] = 20; eye2_hi[1][1] = 23; need[1][1] = 5;
        eye_lo[2][0] = 24; eye_hi[2][0] = 31; need[2][0] = 11;
        eye_lo[2][1] = 0;  eye_hi[2][1] = 31;
        eye_lo[3][1] = 1;  eye_hi[3][1] = 0;
        eye_lo[4][0] = 0;  eye_hi[4][0] = 0;  need[4][0] = 1;
        si0 = slip_i_cnt; sq0 = slip_q_cnt; ce0 = ce_total; dn0 = done_total;
        pulse_start();
        wait_done("main");
        @(negedge clk_i);
        total += 6;
        if (ok_i_o !== 8'hFF) begin bad++; $display("FAIL main_ok_i: got %h required ff", ok_i_o); end
        if (ok_q_o !== 8'hF7) begin bad++; $display("FAIL main_ok_q: got %h required f7", ok_q_o); end
        if (ce_total - ce0 != 31 * 2 * P) begin bad++; $display("FAIL main_ce_count: got %0d required %0d", ce_total - ce0, 31 * 2 * P); end
        if (done_total - dn0 != 1) begin bad++; $display("FAIL main_done_count: got %0d required 1", done_total - dn0); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL main_busy: got %b required 0", busy_o); end
        if (mux_cntrl_o !== 8'd8) begin bad++; $display("FAIL main_mux_idle: got %0d required 8", mux_cntrl_o); end
        for (int l = 0; l < P; l++) begin
            total += 4;
            got = int'(tap_i_o[l*5 +: 5]);
            if (got != exp_ti[l]) begin bad++; $display("FAIL main_tap_i%0d: got %0d required %0d", l, got, exp_ti[l]); end
            got = int'(tap_q_o[l*5 +: 5]);
            if (got != exp_tq[l]) begin bad++; $display("FAIL main_tap_q%0d: got %0d required %0d", l, got, exp_tq[l]); end
            if (slip_i_cnt[l] - si0[l] != exp_si[l]) begin bad++; $display("FAIL main_slips_i%0d: got %0d required %0d", l, slip_i_cnt[l] - si0[l], exp_si[l]); end
            if (slip_q_cnt[l] - sq0[l] != exp_sq[l]) begin bad++; $display("FAIL main_slips_q%0d: got %0d required %0d", l, slip_q_cnt[l] - sq0[l], exp_sq[l]); end
        end
    endtask

    task automatic test_no_pattern();
        int sq6, ce0;
        set_default_cfg();
        need[6][1] = 12;
        sq6 = slip_q_cnt[6]; ce0 = ce_total;
        pulse_start();
        wait_done("nopat");
        total += 5;
        if (slip_q_cnt[6] - sq6 != W) begin bad++; $display("FAIL nopat_slips: got %0d required %0d", slip_q_cnt[6] - sq6, W); end
        if (ok_q_o !== 8'hBF) begin bad++; $display("FAIL nopat_ok_q: got %h required bf", ok_q_o); end
        if (ok_i_o !== 8'hFF) begin bad++; $display("FAIL nopat_ok_i: got %h required ff", ok_i_o); end
        if (tap_q_o[30 +: 5] !== 5'd11) begin bad++; $display("FAIL nopat_tap_q6: got %0d required 11", tap_q_o[30 +: 5]); end
        if (ce_total - ce0 != 31 * 2 * P) begin bad++; $display("FAIL nopat_ce_count: got %0d required %0d", ce_total - ce0, 31 * 2 * P); end
    endtask

    task automatic test_reset_mid_run();
        int dn0;
        set_default_cfg();
        pulse_start();
        wait_mux(5, "midrst");
        repeat (40) @(posedge clk_i);
        #3 rstn_i = 1'b0;
        #1;
        total += 5;
        if (mux_cntrl_o !== 8'd8) begin bad++; $display("FAIL midrst_mux: got %0d required 8", mux_cntrl_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b required 0", busy_o); end
        if ({ok_i_o, ok_q_o} !== '0) begin bad++; $display("FAIL midrst_ok: got %h required 0", {ok_i_o, ok_q_o}); end
        if ({tap_i_o, tap_q_o} !== '0) begin bad++; $display("FAIL midrst_tap: got %h required 0", {tap_i_o, tap_q_o}); end
        if (pulse_vec !== '0) begin bad++; $display("FAIL midrst_pulses: got %b required 0", pulse_vec); end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i) rstn_i = 1'b1;
        repeat (3) @(posedge clk_i);
        dn0 = done_total;
        pulse_start();
        wait_mux(2, "busystart");
        repeat (20) @(posedge clk_i);
        pulse_start();
        repeat (3) @(negedge clk_i);
        total += 3;
        if (mux_cntrl_o !== 8'd2) begin bad++; $display("FAIL busystart_mux: got %0d required 2", mux_cntrl_o); end
        if (ok_i_o !== 8'h03) begin bad++; $display("FAIL busystart_ok_i: got %h required 03", ok_i_o); end
        if (busy_o !== 1'b1) begin bad++; $display("FAIL busystart_busy: got %b required 1", busy_o); end
        wait_done("busystart");
        @(negedge clk_i);
        total += 3;
        if (done_o !== 1'b0) begin bad++; $display("FAIL done_width: got %b required 0", done_o); end
        if (done_total - dn0 != 1) begin bad++; $display("FAIL done_count: got %0d required 1", done_total - dn0); end
        if ({ok_i_o, ok_q_o} !== 16'hFFFF) begin bad++; $display("FAIL busystart_ok: got %h required ffff", {ok_i_o, ok_q_o}); end
    endtask

    task automatic test_back_to_back();
        set_default_cfg();
        eye_lo[7][0] = 16; eye_hi[7][0] = 21;
        pulse_start();
        @(negedge clk_i);
        total += 3;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b required 1", busy_o); end
        if (ok_i_o !== 8'h00) begin bad++; $display("FAIL b2b_ok_clear: got %h required 00", ok_i_o); end
        if (mux_cntrl_o !== 8'd0) begin bad++; $display("FAIL b2b_mux: got %0d required 0", mux_cntrl_o); end
        wait_done("b2b");
        total += 2;
        if (tap_i_o[35 +: 5] !== 5'd18) begin bad++; $display("FAIL b2b_tap_i7: got %0d required 18", tap_i_o[35 +: 5]); end
        if ({ok_i_o, ok_q_o} !== 16'hFFFF) begin bad++; $display("FAIL b2b_ok: got %h required ffff", {ok_i_o, ok_q_o}); end
    endtask

    task automatic test_protocol();
        total += 3;
        if (mux_err != 0) begin bad++; $display("FAIL proto_mux_quiet: got %0d violations required 0", mux_err); end
        if (wide_err != 0) begin bad++; $display("FAIL proto_pulse_width: got %0d violations required 0", wide_err); end
        if (dir_err != 0) begin bad++; $display("FAIL proto_inc_dir: got %0d violations required 0", dir_err); end
    endtask

    initial begin
        set_default_cfg();
        test_reset();
        test_main_run();
        test_no_pattern();
        test_reset_mid_run();
        test_back_to_back();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
